// File: rtl/status_flag_unit.sv
// Condition-code producer: computes NZCV from ALU results and commits them
// to the CPSR flag register, with MSR writes and SPSR save/restore.
module status_flag_unit #(
    parameter int         WIDTH      = 32,
    parameter logic [3:0] RESET_NZCV = 4'h0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             res_valid,
    input  logic [WIDTH-1:0] res_value,
    input  logic             res_carry,
    input  logic             res_overflow,
    input  logic [1:0]       res_kind,
    input  logic             set_flags,
    input  logic             cond_pass,
    input  logic             msr_valid,
    input  logic [3:0]       msr_flags,
    input  logic             exc_entry,
    input  logic             exc_return,
    output logic             flag_n,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_v,
    output logic [3:0]       spsr_flags,
    output logic             flags_pending
);

    localparam logic [1:0] KIND_ARITH = 2'b00;
    localparam logic [1:0] KIND_LOGIC = 2'b01;
    localparam logic [1:0] KIND_MUL   = 2'b10;

    logic [3:0] cpsr;
    logic [3:0] cpsr_next;

    logic       s1_valid;
    logic [3:0] s1_flags;
    logic       s1_wc;
    logic       s1_wv;

    logic       accept;
    logic [3:0] acc_flags;
    logic       acc_wc;
    logic       acc_wv;
    logic [3:0] commit_flags;

    assign accept = res_valid & set_flags & cond_pass & (res_kind != 2'b11);

    always_comb begin
        acc_flags    = 4'b0000;
        acc_wc       = 1'b0;
        acc_wv       = 1'b0;
        acc_flags[3] = res_value[WIDTH-1];
        acc_flags[2] = (res_value == '0);
        acc_flags[1] = res_carry;
        acc_flags[0] = res_overflow;
        unique case (res_kind)
            KIND_ARITH: begin
                acc_wc = 1'b1;
                acc_wv = 1'b1;
            end
            KIND_LOGIC: acc_wc = 1'b1;
            KIND_MUL:   acc_wc = 1'b0;
            default:    acc_wc = 1'b0;
        endcase
    end

    // Kept C/V bits resolve against the CPSR as it stands at commit time,
    // so an intervening MSR or exception return is honoured.
    always_comb begin
        commit_flags    = s1_flags;
        commit_flags[1] = s1_wc ? s1_flags[1] : cpsr[1];
        commit_flags[0] = s1_wv ? s1_flags[0] : cpsr[0];
    end

    always_comb begin
        cpsr_next = cpsr;
        if (exc_return) begin
            cpsr_next = spsr_flags;
        end else if (msr_valid) begin
            cpsr_next = msr_flags;
        end else if (s1_valid) begin
            cpsr_next = commit_flags;
        end
    end

    // Stage 1 always empties (commit or drop), so it simply reloads
    // with whatever stage 0 accepts this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_flags <= 4'b0000;
            s1_wc    <= 1'b0;
            s1_wv    <= 1'b0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_flags <= acc_flags;
                s1_wc    <= acc_wc;
                s1_wv    <= acc_wv;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpsr       <= RESET_NZCV;
            spsr_flags <= 4'b0000;
        end else begin
            cpsr <= cpsr_next;
            if (exc_entry) begin
                spsr_flags <= cpsr_next;
            end
        end
    end

    assign flag_n        = cpsr[3];
    assign flag_z        = cpsr[2];
    assign flag_c        = cpsr[1];
    assign flag_v        = cpsr[0];
    assign flags_pending = s1_valid;

endmodule
